// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction-memory boot loader:
//   state_t         - loader FSM states
//   MAGIC_DEFAULT   - default header byte that opens a load frame
//   BYTES_PER_WORD  - host bytes packed into one instruction word
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } state_t;

  localparam logic [7:0]  MAGIC_DEFAULT  = 8'hA5;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler
// Packs host bytes MSB-first into a 32-bit instruction word.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clear       - restart the byte index at 0 (word contents kept)
//   shift_en    - shift byte_in into the low byte of the word
//   byte_in     - incoming host byte
//   word_out    - current word register
//   word_full   - this shift delivers the last byte of the word
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_full
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;

  // Next word and byte index; index wraps from 3 back to 0 on its own.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear) begin
      idx_d = 2'd0;
    end else if (shift_en) begin
      word_d = {word_q[23:0], byte_in};
      idx_d  = idx_q + 2'd1;
    end else begin
      word_d = word_q;
      idx_d  = idx_q;
    end
  end

  // Word and index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= 32'd0;
      idx_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word_out  = word_q;
  assign word_full = shift_en && (idx_q == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Boot loader for the single-cycle MIPS core. Accepts a host byte stream
// framed as MAGIC, N, then 4*N data bytes (MSB first per word), writes the
// words into instruction memory from word 0 and holds the core in reset
// until the load completes. A MAGIC byte in IDLE/DONE/ERROR (re)starts a load.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte
// (mod-256 sum of the data bytes) that must match before the core is released.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   in_valid/in_ready/in_data - host byte handshake
//   imem_we/imem_addr/imem_wdata - instruction-memory write port
//   cpu_reset                - reset to the processor
//   load_done/load_error     - status of the last load
//   words_loaded             - words written in the current/last load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 5,
  parameter logic [7:0] MAGIC      = MAGIC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            count_q, count_d;
  logic [ADDR_WIDTH:0]   words_q, words_d, words_inc;
  logic                  we_q, we_d;
  logic                  ready_q, ready_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  logic        accept;
  logic        asm_clear;
  logic        asm_shift;
  logic        asm_full;
  logic [31:0] asm_word;

  assign accept    = in_valid && ready_q;
  assign asm_clear = accept && (state_q == COUNT);
  assign asm_shift = accept && (state_q == DATA);
  assign words_inc = words_q + (ADDR_WIDTH+1)'(1);

  imem_word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .shift_en  (asm_shift),
    .byte_in   (in_data),
    .word_out  (asm_word),
    .word_full (asm_full)
  );

  // Loader FSM: frame parsing, address and word counting.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    words_d = words_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        // Only a header byte opens a frame; anything else is dropped.
        if (accept && (in_data == MAGIC)) begin
          state_d = COUNT;
          words_d = {(ADDR_WIDTH+1){1'b0}};
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = 8'd0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      COUNT: begin
        if (accept) begin
          count_d = in_data;
          if (in_data == 8'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DONE;
`endif
          end else if (32'(in_data) > DEPTH) begin
            state_d = ERROR;
          end else begin
            state_d = DATA;
            addr_d  = {ADDR_WIDTH{1'b0}};
          end
        end else begin
          state_d = state_q;
        end
      end
      DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) begin
          sum_d = sum_q + in_data;
        end else begin
          sum_d = sum_q;
        end
`endif
        if (asm_full) begin
          state_d = WRITE;
        end else begin
          state_d = state_q;
        end
      end
      WRITE: begin
        words_d = words_inc;
        // N never exceeds the depth, so the last address is N-1 and never wraps.
        if (32'(words_inc) == 32'(count_q)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          if (in_data == sum_q) begin
            state_d = DONE;
          end else begin
            state_d = ERROR;
          end
        end else begin
          state_d = state_q;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs decoded from the next state so they are registered on entry.
  always_comb begin
    we_d        = (state_d == WRITE);
    ready_d     = (state_d != WRITE);
    cpu_reset_d = (state_d != DONE);
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERROR);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      count_q     <= 8'd0;
      words_q     <= {(ADDR_WIDTH+1){1'b0}};
      we_q        <= 1'b0;
      ready_q     <= 1'b1;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      words_q     <= words_d;
      we_q        <= we_d;
      ready_q     <= ready_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign in_ready     = ready_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = asm_word;
  assign cpu_reset    = cpu_reset_q;
  assign load_done    = done_q;
  assign load_error   = error_q;
  assign words_loaded = words_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Upstream boot stage for the single-cycle MIPS core.
- Receives a byte stream from a host link, packs it into 32-bit instruction words and writes them into instruction memory starting at word 0.
- Holds the core in reset until the load completes.
- A new load can be started at any time; starting one puts the core back into reset.

Parameters:
- ADDR_WIDTH, default 5: instruction-memory word-address bits. Depth is 2**ADDR_WIDTH words; the default gives 32 words.
- MAGIC, default 8'hA5: header byte that starts a load.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- in_valid  input  1  host byte valid
- in_ready  output  1  loader can accept a byte
- in_data  input  8  host byte
- imem_we  output  1  instruction-memory write strobe, one cycle per word
- imem_addr  output  ADDR_WIDTH  word address of the current write
- imem_wdata  output  32  instruction word being written
- cpu_reset  output  1  reset to the processor and its PC register
- load_done  output  1  last load completed successfully
- load_error  output  1  last load failed
- words_loaded  output  ADDR_WIDTH+1  words written in the current/last load

Behaviour:
- Reset values: state IDLE, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, load_done=0, load_error=0, words_loaded=0, in_ready=1. Reset mid-load aborts the load; memory contents already written remain.
- Byte handshake: a byte is accepted on a posedge where in_valid && in_ready. in_ready=0 only in WRITE; it is 1 in every other state.
- Frame format: MAGIC, then count byte N, then 4*N data bytes, MSB first per word.
- IDLE: a MAGIC byte moves to COUNT, clears words_loaded, load_done and load_error, and sets cpu_reset=1. Any other byte is discarded.
- COUNT: N is captured.
  - N=0: go to DONE with no writes.
  - N > 2**ADDR_WIDTH: go to ERROR.
  - Otherwise go to DATA with byte index 0 and address 0.
- DATA: each byte shifts into the word register (word = {word[23:0], byte}). The byte index runs 0..3. On the 4th byte go to WRITE.
- WRITE, one cycle:
  - imem_we=1, with imem_addr and imem_wdata valid in that same cycle.
  - The strobe is registered: the 4th byte accepted at edge k gives imem_we high for the cycle after edge k.
  - words_loaded increments.
  - If words_loaded reaches N: go to DONE (or CHECK when the optional feature is compiled in). Otherwise increment imem_addr and return to DATA.
- DONE: cpu_reset=0 and load_done=1, registered on entry (first cycle after the last write). A MAGIC byte restarts the load as in IDLE. Other bytes are ignored.
- ERROR: cpu_reset=1 and load_error=1. A MAGIC byte restarts the load. Other bytes are ignored.
- A MAGIC value arriving inside COUNT or DATA is treated as data, never as a restart.
- imem_addr never wraps: N is bounded by the depth check, so the final address is N-1.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - A CHECK state follows the last WRITE and accepts one byte.
  - That byte must equal the 8-bit modulo-256 sum of all 4*N data bytes (header bytes excluded).
  - Match goes to DONE; mismatch goes to ERROR, and cpu_reset stays 1.
  - With N=0, COUNT goes to CHECK and the expected checksum is 8'h00.
- When undefined: no CHECK state and no sum register; behaviour is as above.

Decomposition:
- Package imem_loader_pkg holds:
  - typedef enum state_t {IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERROR};
  - localparam MAGIC_DEFAULT=8'hA5;
  - localparam BYTES_PER_WORD=4.
- One sub-module, imem_word_assembler:
  - 32-bit shift register plus 2-bit byte index.
  - Ports: clk, reset, clear, shift_en, byte_in, word_out, word_full.
  - Owns the MSB-first packing and the index wrap at 3.

Test Plan:
- Frame A5,02, bytes 20 08 00 05 20 09 00 03 with in_valid held high -> imem_we pulses twice: addr0=32'h20080005, addr1=32'h20090003. in_ready low for exactly one cycle after each 4th byte. Next cycle after the 2nd write: cpu_reset=0, load_done=1, words_loaded=2.
- Bytes 00,FF before A5, then A5,00 -> leading bytes ignored; no imem_we; DONE with cpu_reset=0. With checksum enabled, a trailing 00 is required for DONE.
- A5,21 with ADDR_WIDTH=5 -> ERROR, load_error=1, cpu_reset=1, no writes. A following A5,01 + 4 bytes -> recovers to DONE.
- Checksum enabled: A5,01,01,02,03,04 then 0A -> DONE. Same frame then 0B -> ERROR, cpu_reset=1.
- reset asserted after the 2nd data byte of word 1 -> all outputs at reset values, IDLE. Fresh A5 frame loads correctly from addr 0.
- In DONE, send A5 -> cpu_reset returns to 1 the next cycle and load_done clears. Random in_valid gaps during the data phase -> identical words written.
